// File: rtl/frame_builder.sv
// Builds a device-to-host response frame (SOF, STATUS, CMD, [ADDR], [DATA], CRC-8) into the UART TX FIFO.
// Define FRAME_BUILDER_ADDR_ECHO_EN to echo the request address in successful read responses.
module frame_builder #(
    parameter logic [7:0] SOF_DEVICE_TO_HOST = 8'h5A,
    parameter int         MAX_DATA_BYTES     = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           build_start,
    input  logic [7:0]                     status,
    input  logic [7:0]                     cmd,
    input  logic [31:0]                    addr,
    input  logic [MAX_DATA_BYTES-1:0][7:0] data_in,
    output logic [7:0]                     tx_fifo_data,
    output logic                           tx_fifo_wr_en,
    input  logic                           tx_fifo_full,
    output logic                           builder_busy,
    output logic                           build_done
);

    localparam int IW = 7;
    localparam int AW = (MAX_DATA_BYTES > 1) ? $clog2(MAX_DATA_BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SOF, S_STATUS, S_CMD, S_ADDR, S_DATA, S_CRC, S_DONE
    } state_t;

    typedef struct packed {
        logic [7:0]  status;
        logic [7:0]  cmd;
        logic [31:0] addr;
    } req_t;

    state_t                           state, state_nx;
    req_t                             req_q;
    logic [MAX_DATA_BYTES-1:0][7:0]   data_q;
    logic [IW-1:0]                    idx_q, idx_nx;
    logic [7:0]                       crc_q, crc_nx;
    logic [IW-1:0]                    len1, len_raw, data_len;
    logic [7:0]                       cur_byte;
    logic                             is_byte, covered, rd_ok;

    // Bit-serial CRC-8 (poly 0x07), MSB first, one whole byte per call.
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[7] ^ b[i]) r = {r[6:0], 1'b0} ^ 8'h07;
            else             r = {r[6:0], 1'b0};
        end
        return r;
    endfunction

    assign rd_ok = req_q.cmd[7] && (req_q.status == 8'h00);

    // Data length: (LEN+1) scaled by access size; SIZE=3 means no data phase.
    always_comb begin
        len1 = IW'(req_q.cmd[3:0]) + IW'(1);
        case (req_q.cmd[5:4])
            2'd0:    len_raw = len1;
            2'd1:    len_raw = len1 << 1;
            2'd2:    len_raw = len1 << 2;
            default: len_raw = '0;
        endcase
        data_len = (len_raw > IW'(MAX_DATA_BYTES)) ? IW'(MAX_DATA_BYTES) : len_raw;
    end

    always_comb begin
        cur_byte = 8'h00;
        is_byte  = 1'b1;
        covered  = 1'b0;
        case (state)
            S_SOF:    cur_byte = SOF_DEVICE_TO_HOST;
            S_STATUS: begin cur_byte = req_q.status; covered = 1'b1; end
            S_CMD:    begin cur_byte = req_q.cmd;    covered = 1'b1; end
            S_ADDR: begin
                covered = 1'b1;
                case (idx_q[1:0])
                    2'd0:    cur_byte = req_q.addr[7:0];
                    2'd1:    cur_byte = req_q.addr[15:8];
                    2'd2:    cur_byte = req_q.addr[23:16];
                    default: cur_byte = req_q.addr[31:24];
                endcase
            end
            S_DATA:   begin cur_byte = data_q[idx_q[AW-1:0]]; covered = 1'b1; end
            S_CRC:    cur_byte = crc_q;
            default:  is_byte = 1'b0;
        endcase
    end

    assign tx_fifo_wr_en = is_byte & ~tx_fifo_full;
    assign tx_fifo_data  = tx_fifo_wr_en ? cur_byte : 8'h00;
    assign builder_busy  = (state != S_IDLE);
    assign build_done    = (state == S_DONE);
    assign crc_nx        = (tx_fifo_wr_en && covered) ? crc8_step(crc_q, cur_byte) : crc_q;

    always_comb begin
        state_nx = state;
        idx_nx   = idx_q;
        case (state)
            S_IDLE:   if (build_start) state_nx = S_SOF;
            S_SOF:    if (tx_fifo_wr_en) state_nx = S_STATUS;
            S_STATUS: if (tx_fifo_wr_en) state_nx = S_CMD;
            S_CMD: if (tx_fifo_wr_en) begin
                idx_nx = '0;
                if (!rd_ok)               state_nx = S_CRC;
`ifdef FRAME_BUILDER_ADDR_ECHO_EN
                else                      state_nx = S_ADDR;
`else
                else if (data_len != '0) state_nx = S_DATA;
                else                      state_nx = S_CRC;
`endif
            end
            S_ADDR: if (tx_fifo_wr_en) begin
                if (idx_q == IW'(3)) begin
                    idx_nx   = '0;
                    state_nx = (data_len != '0) ? S_DATA : S_CRC;
                end else begin
                    idx_nx = idx_q + IW'(1);
                end
            end
            S_DATA: if (tx_fifo_wr_en) begin
                if (idx_q == data_len - IW'(1)) begin
                    idx_nx   = '0;
                    state_nx = S_CRC;
                end else begin
                    idx_nx = idx_q + IW'(1);
                end
            end
            S_CRC:   if (tx_fifo_wr_en) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            req_q  <= '0;
            data_q <= '0;
            idx_q  <= '0;
            crc_q  <= 8'h00;
        end else begin
            state <= state_nx;
            idx_q <= idx_nx;
            if (state == S_IDLE && build_start) begin
                req_q  <= '{status: status, cmd: cmd, addr: addr};
                data_q <= data_in;
                crc_q  <= 8'h00;
            end else begin
                crc_q <= crc_nx;
            end
        end
    end

endmodule

// File: tb/tb_frame_builder.sv
// Randomized self-checking bench for frame_builder against a queue-based frame model.
module tb_frame_builder;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             build_start;
    logic [7:0]       status, cmd;
    logic [31:0]      addr;
    logic [63:0][7:0] data_in;
    logic [7:0]       tx_fifo_data;
    logic             tx_fifo_wr_en, tx_fifo_full, builder_busy, build_done;

`ifdef FRAME_BUILDER_ADDR_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    int         checks = 0, errors = 0, cyc = 0;
    bit         bp_en = 1'b0;
    logic [7:0] got[$], exp_q[$];
    int         first_wr, done_cnt, done_cyc;
    logic [7:0] tbl[256];

    frame_builder dut (
        .clk(clk), .rst_n(rst_n), .build_start(build_start), .status(status), .cmd(cmd),
        .addr(addr), .data_in(data_in), .tx_fifo_data(tx_fifo_data), .tx_fifo_wr_en(tx_fifo_wr_en),
        .tx_fifo_full(tx_fifo_full), .builder_busy(builder_busy), .build_done(build_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Monitor: captures FIFO writes and done pulses, then drives back-pressure for the next cycle.
    initial begin
        tx_fifo_full = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_fifo_wr_en) begin
                chk("no_wr_while_full", {31'd0, tx_fifo_full}, 32'd0);
                got.push_back(tx_fifo_data);
                if (first_wr < 0) first_wr = cyc;
            end else begin
                chk("data_zero_no_wr", {24'd0, tx_fifo_data}, 32'd0);
            end
            if (build_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            tx_fifo_full = bp_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Reference frame: assembled from the field rules, CRC from a lookup table.
    task automatic build_exp(input logic [7:0] st, input logic [7:0] cm, input logic [31:0] ad,
                             input logic [63:0][7:0] d);
        logic [7:0] body[$];
        logic [7:0] c;
        int n;
        body = {};
        body.push_back(st);
        body.push_back(cm);
        if (cm[7] && st == 8'h00) begin
            if (ECHO) for (int k = 0; k < 4; k++) body.push_back(8'(ad >> (8 * k)));
            n = (cm[5:4] == 2'd3) ? 0 : (int'(cm[3:0]) + 1) * (1 << int'(cm[5:4]));
            for (int i = 0; i < n; i++) body.push_back(d[i]);
        end
        c = 8'h00;
        foreach (body[i]) c = tbl[c ^ body[i]];
        exp_q = {};
        exp_q.push_back(8'h5A);
        foreach (body[i]) exp_q.push_back(body[i]);
        exp_q.push_back(c);
    endtask

    task automatic run_frame(input string name, input logic [7:0] st, input logic [7:0] cm,
                             input logic [31:0] ad, input int d0, input bit bp, input bit inject);
        logic [63:0][7:0] d;
        int start_c, t, n;
        for (int i = 0; i < 64; i++) d[i] = 8'($urandom);
        if (d0 >= 0) d[0] = 8'(d0);
        step();
        status = st; cmd = cm; addr = ad; data_in = d;
        build_exp(st, cm, ad, d);
        got = {}; first_wr = -1; done_cnt = 0; done_cyc = -1;
        bp_en = bp;
        start_c = cyc;
        build_start = 1'b1;
        step();
        build_start = 1'b0;
        status = 8'($urandom); cmd = 8'($urandom); addr = $urandom;
        for (int i = 0; i < 64; i++) data_in[i] = 8'($urandom);
        if (inject) begin
            repeat (2) step();
            build_start = 1'b1;
            step();
            build_start = 1'b0;
        end
        t = 0;
        while (done_cnt == 0 && t < 3000) begin
            step();
            t++;
        end
        bp_en = 1'b0;
        chk({name, "_done"}, done_cnt, 1);
        step();
        chk({name, "_single_done"}, done_cnt, 1);
        chk({name, "_idle_after"}, {31'd0, builder_busy}, 32'd0);
        chk({name, "_len"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_byte%0d", name, i), {24'd0, got[i]}, {24'd0, exp_q[i]});
        if (!bp) begin
            chk({name, "_first_wr"}, first_wr, start_c + 1);
            chk({name, "_done_cyc"}, done_cyc, start_c + 1 + exp_q.size());
        end
    endtask

    initial begin
        int t, n0;
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            for (int b = 0; b < 8; b++) v = v[7] ? ((v << 1) ^ 8'h07) : (v << 1);
            tbl[i] = v;
        end
        first_wr = -1; done_cnt = 0;
        rst_n = 1'b0; build_start = 1'b0; status = '0; cmd = '0; addr = '0; data_in = '0;
        #3;
        chk("rst_wr_en", {31'd0, tx_fifo_wr_en}, 32'd0);
        chk("rst_busy", {31'd0, builder_busy}, 32'd0);
        chk("rst_done", {31'd0, build_done}, 32'd0);
        chk("rst_data", {24'd0, tx_fifo_data}, 32'd0);
        repeat (3) step();
        rst_n = 1'b1;

        run_frame("ack", 8'h00, 8'h20, 32'h0, -1, 1'b0, 1'b0);
        if (got.size() == 4) chk("ack_crc_e0", {24'd0, got[3]}, 32'hE0);
        run_frame("err", 8'h01, 8'h80, 32'h12345678, -1, 1'b0, 1'b0);
        run_frame("read", 8'h00, 8'h80, 32'h10000004, 8'hAB, 1'b0, 1'b0);
        run_frame("max", 8'h00, 8'hAF, $urandom, -1, 1'b0, 1'b0);
        chk("max_total", got.size(), ECHO ? 72 : 68);
        run_frame("read_bp", 8'h00, 8'h80, 32'h10000004, 8'hAB, 1'b1, 1'b1);
        run_frame("max_bp", 8'h00, 8'hAF, $urandom, -1, 1'b1, 1'b1);
        for (int r = 0; r < 10; r++)
            run_frame($sformatf("rnd%0d", r), ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                      8'($urandom), $urandom, -1, bit'($urandom_range(0, 1)), 1'b0);

        // Reset in the middle of a long data phase.
        step();
        status = 8'h00; cmd = 8'hAF; addr = $urandom;
        got = {}; first_wr = -1; done_cnt = 0;
        build_start = 1'b1;
        step();
        build_start = 1'b0;
        t = 0;
        while (got.size() < 12 && t < 500) begin
            step();
            t++;
        end
        chk("midrst_progress", got.size(), 12);
        rst_n = 1'b0;
        #1;
        chk("midrst_wr_en", {31'd0, tx_fifo_wr_en}, 32'd0);
        chk("midrst_busy", {31'd0, builder_busy}, 32'd0);
        chk("midrst_done", {31'd0, build_done}, 32'd0);
        n0 = got.size();
        repeat (3) step();
        chk("midrst_no_writes", got.size(), n0);
        chk("midrst_no_done", done_cnt, 0);
        rst_n = 1'b1;
        run_frame("post_rst_ack", 8'h00, 8'h20, 32'h0, -1, 1'b0, 1'b0);
        if (got.size() == 4) chk("post_rst_crc_e0", {24'd0, got[3]}, 32'hE0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_builder.md
FRAME_BUILDER -- requirements
Module: frame_builder

Interface
REQ-001 The block SHALL have parameter SOF_DEVICE_TO_HOST, default 8'h5A, the start-of-frame byte for device-to-host responses.
REQ-002 The block SHALL have parameter MAX_DATA_BYTES, default 64, the capacity of the response data buffer in bytes.
REQ-003 clk  input  1  Single clock; all logic is rising-edge.
REQ-004 rst_n  input  1  Reset; asynchronous assert, active-low.
REQ-005 build_start  input  1  One-cycle request to build a response frame.
REQ-006 status  input  8  Status code for the response (0x00 = OK).
REQ-007 cmd  input  8  Command byte echoed from the request: [7]=RW (1=read), [5:4]=SIZE, [3:0]=LEN.
REQ-008 addr  input  32  Request address.
REQ-009 data_in  input  8 x 64  Read data bytes; index 0 is transmitted first.
REQ-010 tx_fifo_data  output  8  Byte to the UART TX FIFO.
REQ-011 tx_fifo_wr_en  output  1  Write strobe to the TX FIFO.
REQ-012 tx_fifo_full  input  1  TX FIFO full; back-pressure.
REQ-013 builder_busy  output  1  High from build_start acceptance until build_done.
REQ-014 build_done  output  1  One-cycle pulse after the CRC byte is written.

Function
REQ-015 The block SHALL accept build_start only in IDLE, latch status, cmd, addr and data_in on that edge, and ignore build_start in every other state.
REQ-016 The state sequence SHALL be IDLE -> SOF -> STATUS -> CMD -> [ADDR0..ADDR3] -> [DATA] -> CRC -> DONE -> IDLE.
REQ-017 ADDR and DATA SHALL be visited only when the latched cmd[7]=1 and the latched status=0x00; otherwise CMD goes directly to CRC.
REQ-018 ADDR bytes SHALL be sent little-endian (addr[7:0] first).
REQ-019 The DATA byte count SHALL be (LEN+1)x1, x2 or x4 for SIZE 00, 01 or 10, computed 7 bits wide so that 64 is representable; SIZE=11 SHALL give 0 bytes, so DATA is skipped.
REQ-020 In each byte state, tx_fifo_wr_en SHALL be high with the byte on tx_fifo_data exactly when tx_fifo_full=0, and the state SHALL advance only on that cycle.
REQ-021 While tx_fifo_full=1, the block SHALL hold its state and byte index and keep tx_fifo_wr_en=0 for any number of cycles.
REQ-022 The first FIFO write (SOF) SHALL occur in the cycle after build_start is accepted, provided tx_fifo_full=0.
REQ-023 The CRC SHALL be CRC-8 with polynomial 0x07, initial value 0x00, no reflection and no final XOR, computed over every transmitted byte from STATUS through the last DATA byte; SOF SHALL NOT be included.
REQ-024 The CRC SHALL be updated in the same cycle as each covered byte's write, so that the CRC byte carries no bubble cycle.
REQ-025 DONE SHALL last one cycle: build_done=1, no FIFO write, then go to IDLE; a build_start in the following cycle SHALL be accepted.
REQ-026 builder_busy SHALL be 1 in every state except IDLE.
REQ-027 tx_fifo_wr_en SHALL be a combinational function of the state and tx_fifo_full; tx_fifo_data SHALL be 0x00 whenever tx_fifo_wr_en=0.

Reset
REQ-028 While rst_n=0, the block SHALL force state IDLE, the CRC to 0x00, all latched fields and the byte index to 0, and tx_fifo_wr_en, builder_busy and build_done to 0.
REQ-029 When reset is asserted mid-frame, the block SHALL abort immediately with no further FIFO writes; a partial frame already in the FIFO is not recalled.
REQ-030 After rst_n deasserts, the first build_start SHALL be accepted at the next rising edge.

Configuration
REQ-031 With the macro FRAME_BUILDER_ADDR_ECHO_EN defined, successful read responses SHALL include ADDR0..ADDR3 as specified in REQ-017.
REQ-032 Without FRAME_BUILDER_ADDR_ECHO_EN, ADDR states SHALL never be entered: a successful read goes CMD -> DATA, and the address bytes are excluded from the CRC.

Verification
REQ-033 The bench SHALL cover a write ack: status=0x00, cmd=0x20, tx_fifo_full=0 -> FIFO receives 5A 00 20 E0 on 4 consecutive cycles, then build_done for 1 cycle.
REQ-034 The bench SHALL cover an error response: status=0x01, cmd=0x80 -> FIFO receives 5A 01 80 CRC, with no ADDR or DATA bytes.
REQ-035 The bench SHALL cover a read with ECHO_EN: status=0x00, cmd=0x80, addr=0x10000004, data_in[0]=0xAB -> FIFO receives 5A 00 80 04 00 00 10 AB CRC, with the CRC matching a software model.
REQ-036 The bench SHALL cover maximum length: cmd=0xAF (32-bit, LEN=15) -> 64 data bytes in index order, total frame 72 bytes with ECHO_EN.
REQ-037 The bench SHALL cover back-pressure: tx_fifo_full toggles randomly during REQ-035 -> identical byte stream, no write while full, and a build_start while busy is ignored.
REQ-038 The bench SHALL cover reset mid-frame: rst_n low during DATA -> wr_en drops at once, and a new frame after reset is bit-exact per REQ-033.
